// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus controller: FSM encoding, bus base address
// and default access timeout.
package mmio_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDecode = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } mmio_state_e;

  localparam logic [31:0] MMIO_BASE       = 32'hFFFF_0000;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // Width of an index able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_slv_decode.sv
// Checks that exactly one slave claims the address and encodes its index.
module mmio_slv_decode
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_SLV)
) (
  input  logic [NUM_SLV-1:0] i_work,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_hit,
  output logic               o_multi
);

  // OR of the indices of set bits; only meaningful when exactly one bit is set.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (i_work[i]) begin
        o_idx = o_idx | IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more were set.
  assign o_multi = |(i_work & (i_work - NUM_SLV'(1)));
  assign o_hit   = (|i_work) & ~o_multi;

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Single-outstanding MMIO bus master: latches a CPU request, decodes the target
// slave, waits for its done pulse (or a timeout) and returns one ack.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_read,
  input  logic                  i_cpu_write,
  input  logic [31:0]           i_cpu_addr,
  input  logic [31:0]           i_cpu_wdata,
  output logic                  o_cpu_stall,
  output logic                  o_cpu_ack,
  output logic [31:0]           o_cpu_rdata,
  output logic                  o_cpu_buserr,
  output logic                  o_mmio_read,
  output logic                  o_mmio_write,
  output logic [31:0]           o_mmio_addr,
  output logic [31:0]           o_mmio_write_data,
  input  logic [NUM_SLV-1:0]    i_slv_work,
  input  logic [NUM_SLV-1:0]    i_slv_done,
  input  logic [32*NUM_SLV-1:0] i_slv_rdata
);

  localparam int unsigned IdxW = idx_width(NUM_SLV);
  localparam int unsigned CntW = idx_width(TIMEOUT);

  mmio_state_e     r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [IdxW-1:0] r_idx;
  logic            r_is_write;
  logic [31:0]     r_addr, r_wdata, r_rdata;
  logic            r_buserr;

  logic            w_req;
  logic            w_accept;
  logic            w_resp_load;
  logic [31:0]     w_resp_rdata;
  logic            w_resp_err;
  logic [IdxW-1:0] w_dec_idx;
  logic            w_dec_hit;
  logic            w_dec_multi;
  logic [31:0]     w_rdata_arr [NUM_SLV];
  logic [31:0]     w_sel_rdata;

  mmio_slv_decode #(
    .NUM_SLV (NUM_SLV),
    .IDX_W   (IdxW)
  ) u_decode (
    .i_work  (i_slv_work),
    .o_idx   (w_dec_idx),
    .o_hit   (w_dec_hit),
    .o_multi (w_dec_multi)
  );

  always_comb begin
    for (int i = 0; i < NUM_SLV; i++) begin
      w_rdata_arr[i] = i_slv_rdata[32*i +: 32];
    end
  end

  assign w_sel_rdata = w_rdata_arr[r_idx];
  assign w_req       = i_cpu_read | i_cpu_write;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_resp_load  = 1'b0;
    w_resp_rdata = '0;
    w_resp_err   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          w_accept     = 1'b1;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        // w_dec_multi is folded into w_dec_hit; none or several claimants both error out
        if (w_dec_hit) begin
          w_cnt_next   = '0;
          w_state_next = StAccess;
        end else begin
          w_resp_load  = 1'b1;
          w_resp_err   = 1'b1;
          w_state_next = StResp;
        end
      end
      StAccess: begin
        if (i_slv_done[r_idx]) begin
          w_resp_load  = 1'b1;
          w_resp_rdata = r_is_write ? 32'h0 : w_sel_rdata;
          w_state_next = StResp;
        end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
          w_resp_load  = 1'b1;
          w_resp_err   = 1'b1;
          w_state_next = StResp;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      StResp: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_buserr   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr     <= i_cpu_addr;
        r_wdata    <= i_cpu_wdata;
        r_is_write <= i_cpu_write;
      end
      if (r_state == StDecode) begin
        r_idx <= w_dec_idx;
      end
      if (w_resp_load) begin
        r_rdata  <= w_resp_rdata;
        r_buserr <= w_resp_err;
      end
    end
  end

  assign o_cpu_stall       = ((r_state == StIdle) & w_req) | (r_state == StDecode) |
                             (r_state == StAccess);
  assign o_cpu_ack         = (r_state == StResp);
  assign o_cpu_rdata       = r_rdata;
  assign o_cpu_buserr      = r_buserr;
  assign o_mmio_read       = ((r_state == StDecode) | (r_state == StAccess)) & ~r_is_write;
  assign o_mmio_write      = ((r_state == StDecode) | (r_state == StAccess)) & r_is_write;
  assign o_mmio_addr       = r_addr;
  assign o_mmio_write_data = r_wdata;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl: directed scenarios plus random transactions
// against a transaction-level reference model and a behavioural slave bank.
module tb_mmio_bus_ctrl;
  import mmio_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_read, cpu_write;
  logic [31:0]       cpu_addr, cpu_wdata;
  logic              cpu_stall, cpu_ack, cpu_buserr;
  logic [31:0]       cpu_rdata;
  logic              mmio_read, mmio_write;
  logic [31:0]       mmio_addr, mmio_wdata;
  logic [NS-1:0]     slv_work;
  logic [NS-1:0]     slv_done = '0;
  logic [32*NS-1:0]  slv_rdata;

  int checks   = 0;
  int failures = 0;

  mmio_bus_ctrl #(
    .NUM_SLV (NS),
    .TIMEOUT (TO)
  ) dut (
    .i_sys_clk         (clk),
    .i_rst             (rst),
    .i_cpu_read        (cpu_read),
    .i_cpu_write       (cpu_write),
    .i_cpu_addr        (cpu_addr),
    .i_cpu_wdata       (cpu_wdata),
    .o_cpu_stall       (cpu_stall),
    .o_cpu_ack         (cpu_ack),
    .o_cpu_rdata       (cpu_rdata),
    .o_cpu_buserr      (cpu_buserr),
    .o_mmio_read       (mmio_read),
    .o_mmio_write      (mmio_write),
    .o_mmio_addr       (mmio_addr),
    .o_mmio_write_data (mmio_wdata),
    .i_slv_work        (slv_work),
    .i_slv_done        (slv_done),
    .i_slv_rdata       (slv_rdata)
  );

  always #5 clk = ~clk;

  // Slave bank: slave k claims MMIO_BASE page 0 addresses with addr[8:7] == k.
  logic        force_multi = 1'b0;
  int          lat_cfg     = 1;
  bit          noise       = 1'b0;
  logic [31:0] srd [NS];
  int          done_cnt    = 0;
  int          age         = 0;
  bit          served      = 1'b0;
  logic [1:0]  sel, alt;
  logic        mapped, bus_req, single;

  assign sel     = mmio_addr[8:7];
  assign alt     = sel + 2'd1;
  assign mapped  = (mmio_addr[31:16] == MMIO_BASE[31:16]) && (mmio_addr[15:12] == 4'h0);
  assign bus_req = mmio_read | mmio_write;
  assign single  = $onehot(slv_work);

  always_comb begin
    slv_work = '0;
    if (mapped) slv_work[sel] = 1'b1;
    if (mapped && force_multi) slv_work[alt] = 1'b1;
  end

  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < NS; i++) slv_rdata[32*i +: 32] = srd[i];
  end

  // lat_cfg = k: done pulses k cycles after the slave first sees the request; 0 = never.
  always @(posedge clk) begin
    slv_done <= '0;
    if (!bus_req) begin
      age    <= 0;
      served <= 1'b0;
    end else begin
      if (noise && single) slv_done[alt] <= 1'b1;
      if (single && !served && lat_cfg != 0 && age + 1 == lat_cfg) begin
        slv_done[sel] <= 1'b1;
        served        <= 1'b1;
        done_cnt      <= done_cnt + 1;
      end
      age <= age + 1;
    end
  end

  logic [31:0] last_rd;
  logic        last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the ack cycle with the request dropped.
  task automatic run_txn(input string tag, input bit wr, input bit both,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit multi, input int lat, input bit in_resp);
    int          acc, exp_edges, edges, reqc;
    bit          err, got, stall_ok, is_mapped;
    logic [31:0] erd;
    int          tgt;
    is_mapped = (addr[31:16] == 16'hFFFF) && (addr[15:12] == 4'h0);
    tgt       = int'(addr[8:7]);
    if (!is_mapped || multi) begin
      acc = 0; err = 1'b1; erd = 32'h0;
    end else if (lat >= 1 && lat <= int'(TO)) begin
      acc = lat; err = 1'b0; erd = wr ? 32'h0 : srd[tgt];
    end else begin
      acc = int'(TO); err = 1'b1; erd = 32'h0;
    end
    exp_edges = 2 + acc + (in_resp ? 1 : 0);

    force_multi = multi;
    lat_cfg     = lat;
    cpu_write   = wr;
    cpu_read    = !wr || both;
    cpu_addr    = addr;
    cpu_wdata   = wdata;
    #1;
    chk({tag, ".stall_first"}, 32'(cpu_stall), in_resp ? 32'd0 : 32'd1);
    edges = 0; reqc = 0; got = 1'b0; stall_ok = 1'b1;
    while (!got && edges < 60) begin
      @(negedge clk);
      edges++;
      if (mmio_read || mmio_write) begin
        reqc++;
        if (reqc == 1) begin
          chk({tag, ".mmio_addr"}, mmio_addr, addr);
          chk({tag, ".mmio_wdata"}, mmio_wdata, wdata);
          chk({tag, ".mmio_dir"}, {30'd0, mmio_write, mmio_read}, wr ? 32'd2 : 32'd1);
        end
      end
      if (cpu_ack) got = 1'b1;
      else if (!cpu_stall) stall_ok = 1'b0;
    end
    chk({tag, ".ack_latency"}, 32'(edges), 32'(exp_edges));
    chk({tag, ".req_cycles"}, 32'(reqc), 32'(1 + acc));
    chk({tag, ".stall_wait"}, 32'(stall_ok), 32'd1);
    chk({tag, ".rdata"}, cpu_rdata, erd);
    chk({tag, ".buserr"}, 32'(cpu_buserr), 32'(err));
    chk({tag, ".stall_resp"}, 32'(cpu_stall), 32'd0);
    last_rd  = erd;
    last_err = err;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  // One idle cycle after an ack: ack gone, response held, no stall.
  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, ".ack_pulse"}, 32'(cpu_ack), 32'd0);
    chk({tag, ".rdata_hold"}, cpu_rdata, last_rd);
    chk({tag, ".buserr_hold"}, 32'(cpu_buserr), 32'(last_err));
    chk({tag, ".stall_idle"}, 32'(cpu_stall), 32'd0);
  endtask

  initial begin
    int          d0, acks;
    bit          wr, both, mul, b2b, nxt;
    int          kind, idx, lat;
    logic [31:0] addr;

    rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < NS; i++) srd[i] = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset.ack", 32'(cpu_ack), 32'd0);
    chk("reset.buserr", 32'(cpu_buserr), 32'd0);
    chk("reset.rdata", cpu_rdata, 32'd0);
    chk("reset.mmio_req", {30'd0, mmio_write, mmio_read}, 32'd0);
    chk("reset.mmio_addr", mmio_addr, 32'd0);
    chk("reset.mmio_wdata", mmio_wdata, 32'd0);
    chk("reset.stall", 32'(cpu_stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal read from slave 1.
    srd[1] = 32'h1;
    run_txn("rd_s1", 1'b0, 1'b0, 32'hFFFF_0084, 32'h0, 1'b0, 1, 1'b0);
    idle_check("rd_s1");

    // Write, with spurious done from another slave; exactly one done from the target.
    noise = 1'b1;
    d0 = done_cnt;
    run_txn("wr_s1", 1'b1, 1'b0, 32'hFFFF_0080, 32'h1, 1'b0, 1, 1'b0);
    idle_check("wr_s1");
    chk("wr_s1.done_count", 32'(done_cnt - d0), 32'd1);
    noise = 1'b0;

    // Illegal read+write is a write.
    srd[3] = 32'hDEAD_BEEF;
    run_txn("rw_both", 1'b1, 1'b1, 32'hFFFF_0180, 32'h55, 1'b0, 2, 1'b0);
    idle_check("rw_both");

    run_txn("unmapped", 1'b0, 1'b0, 32'hFFFF_1000, 32'h0, 1'b0, 1, 1'b0);
    idle_check("unmapped");

    run_txn("timeout", 1'b0, 1'b0, 32'hFFFF_0000, 32'h0, 1'b0, 0, 1'b0);
    idle_check("timeout");

    // Done on the very last ACCESS cycle still completes normally.
    srd[0] = 32'h0000_7777;
    run_txn("last_cycle", 1'b0, 1'b0, 32'hFFFF_0004, 32'h0, 1'b0, int'(TO), 1'b0);
    idle_check("last_cycle");

    run_txn("multi", 1'b0, 1'b0, 32'hFFFF_0080, 32'h0, 1'b1, 1, 1'b0);
    idle_check("multi");

    // Back-to-back read then write.
    srd[2] = 32'hA5A5_0001;
    run_txn("b2b_rd", 1'b0, 1'b0, 32'hFFFF_0100, 32'h0, 1'b0, 2, 1'b0);
    run_txn("b2b_wr", 1'b1, 1'b0, 32'hFFFF_0000, 32'h1234, 1'b0, 1, 1'b1);
    idle_check("b2b_wr");

    // Leave non-zero response data, then reset in the middle of ACCESS.
    run_txn("pre_rst", 1'b0, 1'b0, 32'hFFFF_0100, 32'h0, 1'b0, 1, 1'b0);
    idle_check("pre_rst");
    lat_cfg = 3; force_multi = 1'b0;
    cpu_read = 1'b1; cpu_addr = 32'hFFFF_0100;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    rst = 1'b1; cpu_read = 1'b0;
    @(negedge clk);
    chk("mid_rst.ack", 32'(cpu_ack), 32'd0);
    chk("mid_rst.buserr", 32'(cpu_buserr), 32'd0);
    chk("mid_rst.rdata", cpu_rdata, 32'd0);
    chk("mid_rst.mmio_req", {30'd0, mmio_write, mmio_read}, 32'd0);
    chk("mid_rst.mmio_addr", mmio_addr, 32'd0);
    chk("mid_rst.mmio_wdata", mmio_wdata, 32'd0);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (cpu_ack || cpu_stall) acks++;
    end
    chk("mid_rst.no_ack", 32'(acks), 32'd0);

    // Random transactions.
    b2b = 1'b0;
    for (int t = 0; t < 30; t++) begin
      wr   = 1'($urandom_range(0, 1));
      both = wr & 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      mul  = (kind == 0);
      idx  = int'($urandom_range(0, NS - 1));
      lat  = int'($urandom_range(0, 10));
      for (int s = 0; s < NS; s++) srd[s] = $urandom();
      if (kind == 1) addr = MMIO_BASE | 32'h0000_2000 | 32'($urandom_range(0, 511));
      else addr = MMIO_BASE | (32'(idx) << 7) | 32'($urandom_range(0, 127));
      noise = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", t), wr, both, addr, $urandom(), mul, lat, b2b);
      nxt = 1'($urandom_range(0, 1));
      if (!nxt) idle_check($sformatf("rnd%0d", t));
      b2b = nxt;
    end
    if (b2b) idle_check("rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
